// File: rtl/stat_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : stat_pkg                                                  |
// | Purpose  : Shared constants and FSM encoding for stat_finalize.      |
// |            DEF_FRAC_BITS / DEF_DIV_W are the default fixed-point     |
// |            fraction width and divider length; MEAN_W / VAR_W are the |
// |            result widths; LATENCY is start-to-done for N != 0.       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package stat_pkg;

  localparam int DEF_FRAC_BITS = 8;
  localparam int DEF_DIV_W     = 64;
  localparam int DVSR_W        = 16;
  localparam int MEAN_W        = 24;
  localparam int VAR_W         = 40;
  localparam int LATENCY       = 2 * DEF_DIV_W + 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    DIV_MEAN = 3'd2,
    DIV_MSQ  = 3'd3,
    FINISH   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/stat_finalize_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : stat_finalize_if                                          |
// | Purpose  : Request/result bundle between the accumulator side        |
// |            (master) and stat_finalize (slave).                       |
// | Ports    : start, sum_in[63:0], sum_square_in[63:0], n_samples[15:0] |
// |            master->slave; busy, done, div_by_zero, mean_out[23:0],   |
// |            var_out[39:0] slave->master.                              |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface stat_finalize_if;
  import stat_pkg::*;

  logic              start;
  logic [63:0]       sum_in;
  logic [63:0]       sum_square_in;
  logic [15:0]       n_samples;
  logic              busy;
  logic              done;
  logic              div_by_zero;
  logic [MEAN_W-1:0] mean_out;
  logic [VAR_W-1:0]  var_out;

  modport master (
    output start, sum_in, sum_square_in, n_samples,
    input  busy, done, div_by_zero, mean_out, var_out
  );

  modport slave (
    input  start, sum_in, sum_square_in, n_samples,
    output busy, done, div_by_zero, mean_out, var_out
  );

endinterface
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seq_divider                                               |
// | Purpose  : Restoring unsigned DIV_W / DVSR_W divider, one quotient   |
// |            bit per cycle. The load cycle already performs the first  |
// |            iteration, so valid rises DIV_W-1 cycles after load.      |
// | Ports    : clk, reset (sync, active-high), load, dividend, divisor;  |
// |            quotient (held until next load), valid.                   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module seq_divider #(
  parameter int DIV_W  = 64,
  parameter int DVSR_W = 16
) (
  input  wire              clk,
  input  wire              reset,
  input  wire              load,
  input  wire [DIV_W-1:0]  dividend,
  input  wire [DVSR_W-1:0] divisor,
  output logic [DIV_W-1:0] quotient,
  output logic             valid
);

  localparam int              CNT_W  = $clog2(DIV_W + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DIV_W);

  logic [DIV_W-1:0]  r_q;
  logic [DVSR_W-1:0] r_rem;
  logic [DVSR_W-1:0] r_dvsr;
  logic [CNT_W-1:0]  r_cnt;

  logic [DIV_W-1:0]  w_q_src;
  logic [DVSR_W-1:0] w_rem_src;
  logic [DVSR_W-1:0] w_dvsr;
  logic [DVSR_W:0]   w_trial;
  logic              w_fits;
  logic              w_step;

  // On load the step operates on the fresh operands instead of the registers.
  always_comb begin
    w_q_src   = load ? dividend : r_q;
    w_rem_src = load ? '0 : r_rem;
    w_dvsr    = load ? divisor : r_dvsr;
    w_trial   = {w_rem_src, w_q_src[DIV_W-1]};
    w_fits    = (w_trial >= {1'b0, w_dvsr});
  end

  assign w_step = (r_cnt != '0) && (r_cnt != C_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q    <= '0;
      r_rem  <= '0;
      r_dvsr <= '0;
      r_cnt  <= '0;
    end else if (load || w_step) begin
      r_q    <= {w_q_src[DIV_W-2:0], w_fits};
      // The true difference is < divisor, so the low DVSR_W bits are exact.
      r_rem  <= w_fits ? (w_trial[DVSR_W-1:0] - w_dvsr) : w_trial[DVSR_W-1:0];
      r_dvsr <= w_dvsr;
      r_cnt  <= load ? CNT_W'(1) : r_cnt + CNT_W'(1);
    end
  end

  assign quotient = r_q;
  assign valid    = (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/stat_finalize.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : stat_finalize                                             |
// | Purpose  : Mean and population variance of accumulated samples in    |
// |            unsigned Q.FRAC_BITS, using one shared sequential divider |
// |            for sum/N and sum_square/N.                               |
// | Ports    : clk, reset (sync, active-high), bus (stat_finalize_if     |
// |            slave: start, sum_in, sum_square_in, n_samples, busy,     |
// |            done, div_by_zero, mean_out, var_out).                    |
// | Options  : STAT_ROUND_EN - adds N>>1 to each dividend (round half    |
// |            up); undefined gives truncating division.                 |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module stat_finalize
  import stat_pkg::*;
#(
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  parameter int DIV_W     = DEF_DIV_W
) (
  input wire             clk,
  input wire             reset,
  stat_finalize_if.slave bus
);

  state_t            r_state;
  state_t            w_state_nxt;

  logic [63:0]       r_sum;
  logic [63:0]       r_sq;
  logic [DVSR_W-1:0] r_n;
  logic [MEAN_W-1:0] r_mean_q;
  logic [MEAN_W-1:0] r_mean_out;
  logic [VAR_W-1:0]  r_var_out;
  logic              r_dbz;

  logic              w_n_zero;
  logic              w_accept;
  logic              w_div_load;
  logic              w_div_valid;
  logic [DIV_W-1:0]  w_div_dvd;
  logic [DIV_W-1:0]  w_quot;
  logic [DIV_W-1:0]  w_bias;
  logic [DIV_W-1:0]  w_mean_dvd;
  logic [DIV_W-1:0]  w_msq_dvd;
  logic [2*MEAN_W-1:0] w_prod;
  logic [DIV_W-1:0]  w_prod_ext;
  logic [DIV_W-1:0]  w_d;
  logic [VAR_W-1:0]  w_var;
  logic              w_mean_cap;
  logic              w_res_cap;
  logic              w_busy;
  logic              w_done;

  assign w_n_zero = (r_n == '0);
  assign w_accept = (r_state == IDLE) && bus.start;

`ifdef STAT_ROUND_EN
  assign w_bias = DIV_W'(r_n >> 1);
`else
  assign w_bias = '0;
`endif

  assign w_mean_dvd = DIV_W'(r_sum << FRAC_BITS) + w_bias;
  assign w_msq_dvd  = DIV_W'(r_sq << (2 * FRAC_BITS)) + w_bias;

  // In DIV_MSQ the divider quotient is msq_q; the result is formed from it
  // directly so the outputs are already valid in the FINISH (done) cycle.
  assign w_prod     = {{MEAN_W{1'b0}}, r_mean_q} * {{MEAN_W{1'b0}}, r_mean_q};
  assign w_prod_ext = DIV_W'(w_prod);
  assign w_d        = (w_quot >= w_prod_ext) ? (w_quot - w_prod_ext) : '0;
  assign w_var      = VAR_W'(w_d >> FRAC_BITS);

  seq_divider #(
    .DIV_W  (DIV_W),
    .DVSR_W (DVSR_W)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .load     (w_div_load),
    .dividend (w_div_dvd),
    .divisor  (r_n),
    .quotient (w_quot),
    .valid    (w_div_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (bus.start) w_state_nxt = LOAD;
      LOAD:     w_state_nxt = w_n_zero ? IDLE : DIV_MEAN;
      DIV_MEAN: if (w_div_valid) w_state_nxt = DIV_MSQ;
      DIV_MSQ:  if (w_div_valid) w_state_nxt = FINISH;
      FINISH:   w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_div_load = 1'b0;
    w_div_dvd  = w_mean_dvd;
    w_mean_cap = 1'b0;
    w_res_cap  = 1'b0;
    w_busy     = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      LOAD: begin
        w_div_load = !w_n_zero;
        w_done     = w_n_zero;
      end
      DIV_MEAN: begin
        w_busy     = 1'b1;
        w_div_dvd  = w_msq_dvd;
        w_div_load = w_div_valid;
        w_mean_cap = w_div_valid;
      end
      DIV_MSQ: begin
        w_busy    = 1'b1;
        w_res_cap = w_div_valid;
      end
      FINISH: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum      <= '0;
      r_sq       <= '0;
      r_n        <= '0;
      r_mean_q   <= '0;
      r_mean_out <= '0;
      r_var_out  <= '0;
      r_dbz      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sum <= bus.sum_in;
        r_sq  <= bus.sum_square_in;
        r_n   <= bus.n_samples;
        // N==0 finishes in LOAD, so its zero result is staged on acceptance
        // to be visible together with done.
        r_dbz <= (bus.n_samples == '0);
        if (bus.n_samples == '0) begin
          r_mean_out <= '0;
          r_var_out  <= '0;
        end
      end
      if (w_mean_cap) begin
        r_mean_q <= MEAN_W'(w_quot);
      end
      if (w_res_cap) begin
        r_mean_out <= r_mean_q;
        r_var_out  <= w_var;
      end
    end
  end

  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.mean_out    = r_mean_out;
  assign bus.var_out     = r_var_out;

endmodule
`default_nettype wire
